// File: rtl/player_pkg.sv
// Shared types, animation codes and arithmetic helpers for the player motion controller.
package player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_STUNNED
  } state_e;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  localparam logic [3:0] ANIM_IDLE       = 4'd0;
  localparam logic [3:0] ANIM_WALK_UP    = 4'd1;
  localparam logic [3:0] ANIM_WALK_DOWN  = 4'd2;
  localparam logic [3:0] ANIM_WALK_LEFT  = 4'd3;
  localparam logic [3:0] ANIM_WALK_RIGHT = 4'd4;
  localparam logic [3:0] ANIM_STUN       = 4'd5;
  localparam logic [3:0] ANIM_BOMB       = 4'd6;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold maxval; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

  // One saturating grid step: inc=1 moves towards vmax, inc=0 towards zero.
  function automatic int unsigned step_coord(input int unsigned v, input logic inc,
                                             input int unsigned vmax);
    if (inc) return (v >= vmax) ? v : v + 1;
    else     return (v == 0) ? 0 : v - 1;
  endfunction

  function automatic logic [3:0] walk_anim(input dir_e d);
    case (d)
      DIR_UP:    return ANIM_WALK_UP;
      DIR_DOWN:  return ANIM_WALK_DOWN;
      DIR_LEFT:  return ANIM_WALK_LEFT;
      DIR_RIGHT: return ANIM_WALK_RIGHT;
      default:   return ANIM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/player_motion_ctrl_tick_timer.sv
// Loadable down-counter that stops at zero; used for move pacing, stun and bomb cooldown.
module player_tick_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load_i)
      value_d = load_val_i;
    else if (dec_i && (value_q != '0))
      value_d = value_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player controller: held WASD to paced grid steps, stun interrupt, bomb req/ack handshake.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int unsigned COORD_W       = 6,
  parameter int unsigned GRID_MAX_X    = 39,
  parameter int unsigned GRID_MAX_Y    = 29,
  parameter int unsigned START_X       = 0,
  parameter int unsigned START_Y       = 0,
  parameter int unsigned MOVE_DIV      = 4,
  parameter int unsigned STUN_CYCLES   = 8,
  parameter int unsigned BOMB_COOLDOWN = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               directionUp,
  input  logic               directionDown,
  input  logic               directionLeft,
  input  logic               directionRight,
  input  logic               bombEnable,
  input  logic               bombAck,
  input  logic               stunnedEffect,
  output logic               bombRequested,
  output logic [COORD_W-1:0] positionX,
  output logic [COORD_W-1:0] positionY,
  output logic [3:0]         animationAction
);

  localparam int unsigned TMR_W = timer_width(max3(MOVE_DIV, STUN_CYCLES, BOMB_COOLDOWN));
  localparam logic [TMR_W-1:0] MOVE_RELOAD = TMR_W'(MOVE_DIV - 1);
  localparam logic [TMR_W-1:0] STUN_RELOAD = TMR_W'(STUN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CD_RELOAD   = TMR_W'(BOMB_COOLDOWN);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  dir_e               dir_in;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               req_q, req_d;
  logic [3:0]         anim_q, anim_d;

  logic               mv_load, mv_dec, mv_zero;
  logic               st_load, st_dec, st_zero;
  logic               cd_load, cd_dec, cd_zero;
  logic               do_step;
  logic [TMR_W-1:0]   mv_val, st_val, cd_val;
  logic               timers_unused;

  always_comb begin
    dir_in = DIR_NONE;
    if      (directionUp)    dir_in = DIR_UP;
    else if (directionDown)  dir_in = DIR_DOWN;
    else if (directionLeft)  dir_in = DIR_LEFT;
    else if (directionRight) dir_in = DIR_RIGHT;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    mv_load = 1'b0;
    mv_dec  = 1'b0;
    st_load = 1'b0;
    st_dec  = 1'b0;
    do_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stunnedEffect) begin
          state_d = ST_STUNNED;
          st_load = 1'b1;
        end else if (dir_in != DIR_NONE) begin
          state_d = ST_MOVE;
          dir_d   = dir_in;
          do_step = 1'b1;
          mv_load = 1'b1;
        end
      end
      ST_MOVE: begin
        if (stunnedEffect) begin
          state_d = ST_STUNNED;
          st_load = 1'b1;
        end else if (dir_in == DIR_NONE) begin
          state_d = ST_IDLE;
        end else if ((dir_in != dir_q) || mv_zero) begin
          dir_d   = dir_in;
          do_step = 1'b1;
          mv_load = 1'b1;
        end else begin
          mv_dec = 1'b1;
        end
      end
      ST_STUNNED: begin
        if (stunnedEffect)
          st_load = 1'b1;
        else if (st_zero)
          state_d = ST_IDLE;
        else
          st_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (do_step) begin
      case (dir_in)
        DIR_UP:    y_d = COORD_W'(step_coord(32'(y_q), 1'b0, GRID_MAX_Y));
        DIR_DOWN:  y_d = COORD_W'(step_coord(32'(y_q), 1'b1, GRID_MAX_Y));
        DIR_LEFT:  x_d = COORD_W'(step_coord(32'(x_q), 1'b0, GRID_MAX_X));
        DIR_RIGHT: x_d = COORD_W'(step_coord(32'(x_q), 1'b1, GRID_MAX_X));
        default: ;
      endcase
    end
  end

  // The stun gate looks at the registered state, so a stun arriving this cycle does not block.
  always_comb begin
    req_d   = req_q;
    cd_load = 1'b0;
    if (req_q) begin
      if (bombAck) begin
        req_d   = 1'b0;
        cd_load = 1'b1;
      end
    end else if (bombEnable && (state_q != ST_STUNNED) && cd_zero) begin
      req_d = 1'b1;
    end
    cd_dec = !cd_load;
  end

  always_comb begin
    anim_d = ANIM_IDLE;
    if (state_d == ST_STUNNED)   anim_d = ANIM_STUN;
    else if (req_d)              anim_d = ANIM_BOMB;
    else if (state_d == ST_MOVE) anim_d = walk_anim(dir_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      x_q     <= COORD_W'(START_X);
      y_q     <= COORD_W'(START_Y);
      req_q   <= 1'b0;
      anim_q  <= ANIM_IDLE;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      req_q   <= req_d;
      anim_q  <= anim_d;
    end
  end

  player_tick_timer #(.W(TMR_W)) u_move_tmr (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (mv_load),
    .load_val_i (MOVE_RELOAD),
    .dec_i      (mv_dec),
    .value_o    (mv_val),
    .zero_o     (mv_zero)
  );

  player_tick_timer #(.W(TMR_W)) u_stun_tmr (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (st_load),
    .load_val_i (STUN_RELOAD),
    .dec_i      (st_dec),
    .value_o    (st_val),
    .zero_o     (st_zero)
  );

  player_tick_timer #(.W(TMR_W)) u_cool_tmr (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (cd_load),
    .load_val_i (CD_RELOAD),
    .dec_i      (cd_dec),
    .value_o    (cd_val),
    .zero_o     (cd_zero)
  );

  assign timers_unused = ^{mv_val, st_val, cd_val};

  assign bombRequested   = req_q;
  assign positionX       = x_q;
  assign positionY       = y_q;
  assign animationAction = anim_q;

endmodule
